cpu_run_ctrl: RTL and testbench

Run/step/halt sequencer for the single-cycle ARM core and its imem/dmem. It produces a clock enable `cpu_en` for the processor, replacing combinational clock gating, so the core runs on the free-running 50 MHz clock. It stops the core on a PC limit, a cycle timeout, a user halt or a detected success store. It drives the success/fail LEDs and a retired-cycle counter for the 7-segment displays.

---
 rtl/cpu_run_pkg.sv | 30 +++
 rtl/cpu_run_ctrl_btn.sv | 34 +++
 rtl/cpu_run_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the run/step/halt sequencer of the single-cycle core.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } run_state_t;

  localparam logic [31:0] DEF_PC_LIMIT       = 32'd100;
  localparam logic [31:0] DEF_SUCCESS_ADDR   = 32'd100;
  localparam logic [31:0] DEF_SUCCESS_DATA   = 32'd7;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1024;
  localparam int unsigned DEF_CNT_W          = 32'd16;

  // A store only counts as the success marker when both address and data match.
  function automatic logic is_success_store(
    input logic        mem_write,
    input logic [31:0] data_adr,
    input logic [31:0] write_data,
    input logic [31:0] exp_adr,
    input logic [31:0] exp_data
  );
    return mem_write && (data_adr == exp_adr) && (write_data == exp_data);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a rising-edge pulse generator.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [2:0] warm_q, warm_d;

  // warm_q fills once the edge detector sees real samples, so a button held through reset never fires.
  always_comb begin
    sync_d = {sync_q[0], btn_i};
    prev_d = sync_q[1];
    warm_d = {warm_q[1:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      warm_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      warm_q <= warm_d;
    end
  end

  assign pulse_o = sync_q[1] & ~prev_q & warm_q[2];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: gates the core with a clock enable and flags success/fail.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT       = DEF_PC_LIMIT,
  parameter logic [31:0] SUCCESS_ADDR   = DEF_SUCCESS_ADDR,
  parameter logic [31:0] SUCCESS_DATA   = DEF_SUCCESS_DATA,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_btn,
  input  logic [31:0]      pc,
  input  logic             mem_write,
  input  logic [31:0]      data_adr,
  input  logic [31:0]      write_data,
  output logic             cpu_en,
  output logic [2:0]       state,
  output logic             led_success,
  output logic             led_fail,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic run_p, step_p, halt_p;

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             led_success_q, led_success_d;
  logic             led_fail_q, led_fail_d;
  logic             over_s, en_s, hit_s;

  btn_sync_edge u_run_sync (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (run_btn),
    .pulse_o (run_p)
  );

  btn_sync_edge u_step_sync (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (step_btn),
    .pulse_o (step_p)
  );

  btn_sync_edge u_halt_sync (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (halt_btn),
    .pulse_o (halt_p)
  );

  // Enable is combinational so an out-of-range PC never gets its instruction committed.
  always_comb begin
    over_s = (pc > PC_LIMIT) || (64'(count_q) == 64'(TIMEOUT_CYCLES));
    en_s   = ((state_q == RUN) || (state_q == STEP)) && !over_s;
    hit_s  = en_s && is_success_store(mem_write, data_adr, write_data,
                                      SUCCESS_ADDR, SUCCESS_DATA);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, PAUSE: begin
        if (run_p) begin
          state_d = RUN;
        end else if (step_p) begin
          state_d = STEP;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (hit_s) begin
          state_d = DONE;
        end else if (over_s) begin
          state_d = FAIL;
        end else if (halt_p) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      STEP: begin
        if (hit_s) begin
          state_d = DONE;
        end else if (over_s) begin
          state_d = FAIL;
        end else begin
          state_d = PAUSE;
        end
      end
      DONE, FAIL: begin
        state_d = state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Count saturates rather than wrapping so a long run never looks fresh on the display.
  always_comb begin
    if (en_s && (count_q != CNT_MAX)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
    led_success_d = (state_d == DONE);
    led_fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= {CNT_W{1'b0}};
      led_success_q <= 1'b0;
      led_fail_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      led_success_q <= led_success_d;
      led_fail_q    <= led_fail_d;
    end
  end

  assign cpu_en      = en_s;
  assign state       = state_q;
  assign led_success = led_success_q;
  assign led_fail    = led_fail_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a cycle-level reference model plus directed scenarios.
module tb_cpu_run_ctrl;

  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned CW      = 16;
  localparam int unsigned MAXC    = 65535;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run_btn = 1'b0, step_btn = 1'b0, halt_btn = 1'b0;
  logic [31:0]   pc = 32'd0, data_adr = 32'd0, write_data = 32'd0;
  logic          mem_write = 1'b0;
  logic          cpu_en, led_success, led_fail;
  logic [2:0]    dut_state;
  logic [CW-1:0] cycle_count;

  int n_total = 0;
  int n_pass  = 0;

  logic        hold_pc = 1'b0, store_pc_en = 1'b0, store_force = 1'b0;
  logic [31:0] store_pc = 32'd0;

  // reference model (states numbered IDLE=0 RUN=1 STEP=2 PAUSE=3 DONE=4 FAIL=5)
  int          m_state = 0;
  int unsigned m_count = 0;
  int          m_edges = 0;
  logic [2:0]  h_run = 3'b000, h_step = 3'b000, h_halt = 3'b000;
  logic        m_commit = 1'b0;

  cpu_run_ctrl #(
    .PC_LIMIT       (32'd100),
    .SUCCESS_ADDR   (32'd100),
    .SUCCESS_DATA   (32'd7),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .halt_btn    (halt_btn),
    .pc          (pc),
    .mem_write   (mem_write),
    .data_adr    (data_adr),
    .write_data  (write_data),
    .cpu_en      (cpu_en),
    .state       (dut_state),
    .led_success (led_success),
    .led_fail    (led_fail),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic m_over();
    return (pc > 32'd100) || (m_count == TIMEOUT);
  endfunction

  function automatic logic m_en();
    return ((m_state == 1) || (m_state == 2)) && !m_over();
  endfunction

  function automatic logic m_hit();
    return m_en() && mem_write && (data_adr == 32'd100) && (write_data == 32'd7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a button press is seen at the edge two samples after it is first sampled,
  // only once three edges have passed since reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_count = 0; m_edges = 0; m_commit = 1'b0;
      h_run = 3'b000; h_step = 3'b000; h_halt = 3'b000;
    end else begin
      logic en, hit, over, rp, sp, hp;
      en   = m_en();
      hit  = m_hit();
      over = m_over();
      rp   = (m_edges >= 3) && h_run[1]  && !h_run[2];
      sp   = (m_edges >= 3) && h_step[1] && !h_step[2];
      hp   = (m_edges >= 3) && h_halt[1] && !h_halt[2];
      m_commit = en;
      if (en && (m_count < MAXC)) m_count++;
      case (m_state)
        0, 3: if (rp) m_state = 1; else if (sp) m_state = 2;
        1: if (hit) m_state = 4; else if (over) m_state = 5; else if (hp) m_state = 3;
        2: if (hit) m_state = 4; else if (over) m_state = 5; else m_state = 3;
        default: ;
      endcase
      h_run  = {h_run[1:0], run_btn};
      h_step = {h_step[1:0], step_btn};
      h_halt = {h_halt[1:0], halt_btn};
      if (m_edges < 3) m_edges++;
    end
  end

  // Per-cycle comparison, just before each rising edge.
  always @(negedge clk) begin
    #4;
    chk("state",       32'(dut_state),   32'(m_state));
    chk("cpu_en",      32'(cpu_en),      32'(m_en()));
    chk("cycle_count", 32'(cycle_count), m_count);
    chk("led_success", 32'(led_success), 32'(m_state == 4));
    chk("led_fail",    32'(led_fail),    32'(m_state == 5));
  end

  task automatic drive_bus();
    if (store_force || (store_pc_en && (pc == store_pc))) begin
      mem_write = 1'b1; data_adr = 32'd100; write_data = 32'd7;
    end else if (pc == 32'd20) begin
      mem_write = 1'b1; data_adr = 32'd100; write_data = 32'd6;
    end else if (pc == 32'd24) begin
      mem_write = 1'b1; data_adr = 32'd104; write_data = 32'd7;
    end else begin
      mem_write = 1'b0; data_adr = 32'd100; write_data = 32'd7;
    end
  endtask

  // Fake core: PC advances after every committed instruction.
  task automatic tick();
    @(negedge clk);
    if (m_commit && !hold_pc) pc = pc + 32'd4;
    drive_bus();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; pc = 32'd0; run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0;
    hold_pc = 1'b0; store_pc_en = 1'b0; store_force = 1'b0;
    drive_bus();
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_state(input int s, input string name);
    int budget;
    budget = 200;
    while ((m_state != s) && (budget > 0)) begin tick(); budget--; end
    chk(name, 32'(m_state), 32'(s));
  endtask

  task automatic wait_count(input int unsigned c, input string name);
    int budget;
    budget = 200;
    while ((m_count != c) && (budget > 0)) begin tick(); budget--; end
    chk(name, m_count, c);
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) run_btn = 1'b1; else if (which == 1) step_btn = 1'b1; else halt_btn = 1'b1;
    repeat (hold) tick();
    run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset state, halt ignored in IDLE, run to a success store at PC=40
    do_reset();
    #4;
    chk("t1_rst_state", 32'(dut_state), 32'd0);
    chk("t1_rst_count", 32'(cycle_count), 32'd0);
    chk("t1_rst_en", 32'(cpu_en), 32'd0);
    press(2, 5); repeat (3) tick();
    #4; chk("t1_halt_idle", 32'(dut_state), 32'd0);
    store_pc_en = 1'b1; store_pc = 32'd40;
    tick();
    run_btn = 1'b1;
    tick(); tick();
    #4; chk("t1_en_before", 32'(cpu_en), 32'd0);
    tick();
    #4; chk("t1_en_3cyc", 32'(cpu_en), 32'd1);
    chk("t1_run", 32'(dut_state), 32'd1);
    tick(); run_btn = 1'b0;
    press(1, 4);
    wait_state(4, "t1_wait_done");
    #4;
    chk("t1_done", 32'(dut_state), 32'd4);
    chk("t1_led_s", 32'(led_success), 32'd1);
    chk("t1_en_off", 32'(cpu_en), 32'd0);
    chk("t1_count", 32'(cycle_count), 32'd11);
    press(0, 5); repeat (4) tick();
    #4; chk("t1_frozen", 32'(cycle_count), 32'd11);

    // 2: PC ramps past the limit; the store presented at PC=104 must not count
    do_reset();
    store_pc_en = 1'b1; store_pc = 32'd104;
    press(0, 4);
    begin
      int budget;
      budget = 200;
      while ((pc != 32'd104) && (budget > 0)) begin tick(); budget--; end
    end
    #4;
    chk("t2_pc_at_104", pc, 32'd104);
    chk("t2_en_104", 32'(cpu_en), 32'd0);
    chk("t2_still_run", 32'(dut_state), 32'd1);
    tick();
    #4;
    chk("t2_fail", 32'(dut_state), 32'd5);
    chk("t2_led_f", 32'(led_fail), 32'd1);
    chk("t2_led_s", 32'(led_success), 32'd0);
    chk("t2_count", 32'(cycle_count), 32'd26);

    // 3: three single steps from IDLE
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(1, 4);
      repeat (4) tick();
      #4;
      chk("t3_pause", 32'(dut_state), 32'd3);
      chk("t3_count", 32'(cycle_count), 32'(i + 1));
    end

    // 4: halt at count 20, resume, then run off the PC limit
    do_reset();
    press(0, 4);
    wait_count(20, "t4_wait20");
    press(2, 5);
    repeat (2) tick();
    #4;
    chk("t4_pause", 32'(dut_state), 32'd3);
    chk("t4_en", 32'(cpu_en), 32'd0);
    chk("t4_count", 32'(cycle_count), 32'd23);
    press(0, 4);
    #4; chk("t4_resume", 32'(dut_state), 32'd1);
    wait_state(5, "t4_wait_fail");
    #4; chk("t4_final_count", 32'(cycle_count), 32'd26);

    // 5: timeout with PC held, then a success store on the last allowed cycle
    do_reset();
    hold_pc = 1'b1;
    press(0, 4);
    wait_state(5, "t5_wait_fail");
    #4;
    chk("t5_fail", 32'(dut_state), 32'd5);
    chk("t5_count", 32'(cycle_count), 32'(TIMEOUT));
    do_reset();
    hold_pc = 1'b1;
    press(0, 4);
    wait_count(TIMEOUT - 1, "t5_wait_last");
    store_force = 1'b1; drive_bus();
    tick();
    store_force = 1'b0; drive_bus();
    #4;
    chk("t5_done_last", 32'(dut_state), 32'd4);
    chk("t5_done_count", 32'(cycle_count), 32'(TIMEOUT));

    // 6: async reset mid-run with run held through release
    do_reset();
    run_btn = 1'b1;
    wait_count(5, "t6_wait5");
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_state", 32'(dut_state), 32'd0);
    chk("t6_rst_en", 32'(cpu_en), 32'd0);
    chk("t6_rst_count", 32'(cycle_count), 32'd0);
    chk("t6_rst_leds", 32'({led_success, led_fail}), 32'd0);
    @(negedge clk);
    pc = 32'd0; drive_bus();
    reset = 1'b1;
    repeat (10) tick();
    #4; chk("t6_no_restart", 32'(dut_state), 32'd0);
    run_btn = 1'b0;
    repeat (3) tick();
    press(0, 4);
    #4; chk("t6_repress", 32'(dut_state), 32'd1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
